// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NREQ producers, the round-robin write arbiter and one FIFO write port.
// Handshake: producer i holds req[i] with stable data; a word moves when ack[i]=1 at a rising clk edge.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int GW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_data;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    modport master (
        output req, req_data, fifo_full,
        input  ack, fifo_wr_en, fifo_data, grant_id, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output ack, fifo_wr_en, fifo_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, granting bursts of up
// to BURST words, stalling on fifo_full, and registering the accepted word onto the FIFO pins.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_wr_arbiter_if.slave      bus,
    output logic                  dbg_state_o
);
    localparam int GW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e                     state_q, state_d;
    logic [GW-1:0]              last_id_q, last_id_d;
    logic [GW-1:0]              grant_id_q, grant_id_d;
    logic [CW-1:0]              burst_cnt_q, burst_cnt_d;
    logic                       wr_en_q, wr_en_d;
    logic [WIDTH-1:0]           data_q, data_d;

    logic [NREQ-1:0][WIDTH-1:0] words;
    logic                       pick_found;
    logic [GW-1:0]              pick_id;
    logic [GW-1:0]              cand;
    logic                       accept;
    logic [NREQ-1:0]            ack_v;
    logic                       busy_v;

    assign words = bus.req_data;

    // Search downwards so the candidate closest after last_id is the one left standing.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = GW'((int'(last_id_q) + k) % NREQ);
            if (bus.req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_id_q   <= GW'(NREQ - 1);
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        wr_en_d     = 1'b0;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    data_d      = words[grant_id_q];
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
                // A full FIFO with the request still up keeps the grant; there is no timeout.
                if ((accept && (burst_cnt_q == CW'(BURST - 1))) || !bus.req[grant_id_q]) begin
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_v  = '0;
        busy_v = 1'b0;
        accept = 1'b0;
        if (state_q == GRANT) begin
            busy_v            = 1'b1;
            accept            = bus.req[grant_id_q] & ~bus.fifo_full;
            ack_v[grant_id_q] = accept;
        end
    end

    assign bus.ack        = ack_v;
    assign bus.busy       = busy_v;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_data  = data_q;
    assign bus.grant_id   = grant_id_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a long random run against a
// cycle-level model of the arbitration rules; FIFO writes are scoreboarded in order.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 2;

  logic clk = 1'b0;
  logic reset;
  logic dbg_state;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // producer side
  logic [NREQ-1:0]  p_req;
  logic [WIDTH-1:0] p_data [NREQ];
  logic [NREQ-1:0]  prev_ack;

  // reference model: current owner (-1 = none), previous owner, words taken this grant
  int m_owner;
  int m_last;
  int m_count;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] wr_log[$];
  int               grant_log[$];
  int               wait_cnt [NREQ];
  logic             prev_busy;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_count = 0;
  endfunction

  task automatic drive_bus();
    bus.req = p_req;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = p_data[i];
  endtask

  // One clock of stimulus: drive at negedge, check ack before the next posedge, advance model.
  task automatic cycle(input bit auto_mode, input int full_pct, input int drop_pct, input int raise_pct);
    logic [NREQ-1:0] exp_ack;
    logic            acc;
    bit              found;
    int              c;
    @(negedge clk);
    if (auto_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (prev_ack[i]) begin
          if ($urandom_range(99) < drop_pct) p_req[i] = 1'b0;
          else p_data[i] = WIDTH'($urandom);
        end else if (!p_req[i] && ($urandom_range(99) < raise_pct)) begin
          p_req[i]  = 1'b1;
          p_data[i] = WIDTH'($urandom);
        end
      end
    end
    bus.fifo_full = ($urandom_range(99) < full_pct);
    drive_bus();
    #1;
    exp_ack = '0;
    acc     = 1'b0;
    if (m_owner >= 0 && p_req[m_owner] && !bus.fifo_full) begin
      acc              = 1'b1;
      exp_ack[m_owner] = 1'b1;
      exp_q.push_back(p_data[m_owner]);
    end
    chk("ack", 32'(bus.ack), 32'(exp_ack));
    prev_ack = exp_ack;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!found && p_req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_count = 0;
        end
      end
    end else begin
      if (acc) m_count++;
      if ((acc && m_count == BURST) || !p_req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    p_req         = '0;
    prev_ack      = '0;
    bus.fifo_full = 1'b0;
    drive_bus();
    exp_q.delete();
    model_reset();
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: scoreboard the FIFO write stream, grant state, and fairness on every new grant.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_write: got unexpected write %0h, expected none (t=%0t)", bus.fifo_data, $time);
        end else begin
          chk("fifo_data", 32'(bus.fifo_data), 32'(exp_q.pop_front()));
        end
        wr_log.push_back(bus.fifo_data);
      end
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      if (m_owner >= 0) chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
      if (bus.busy && !prev_busy) begin
        grant_log.push_back(int'(bus.grant_id));
        for (int i = 0; i < NREQ; i++) begin
          if (i == int'(bus.grant_id)) begin
            wait_cnt[i] = 0;
          end else if (bus.req[i]) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > NREQ - 1) begin
              errors++;
              $display("FAIL fairness: source %0d waited %0d grants, limit %0d", i, wait_cnt[i], NREQ - 1);
            end
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    logic [WIDTH-1:0] w1 [3];
    int idx;
    w1 = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < NREQ; i++) p_data[i] = '0;
    prev_busy = 1'b0;
    reset = 1'b1;
    p_req = '0;
    bus.fifo_full = 1'b0;
    drive_bus();
    #12;
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("reset_data", 32'(bus.fifo_data), 32'd0);
    chk("reset_grant_id", 32'(bus.grant_id), 32'd0);

    // single requester, three words across two grants
    do_reset();
    grant_log.delete();
    wr_log.delete();
    p_req[2] = 1'b1;
    p_data[2] = w1[0];
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 0, 0, 0);
      if (prev_ack[2]) begin
        idx++;
        if (idx < 3) p_data[2] = w1[idx];
        else p_req[2] = 1'b0;
      end
    end
    chk("t1_writes", 32'(wr_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t1_word", 32'((wr_log.size() > i) ? wr_log[i] : 8'h00), 32'(w1[i]));
    chk("t1_grants", 32'(grant_log.size()), 32'd2);

    // full stalls an active grant on requester 1
    do_reset();
    p_req[1] = 1'b1;
    p_data[1] = 8'h5A;
    cycle(1'b0, 0, 0, 0);
    repeat (3) begin
      cycle(1'b0, 100, 0, 0);
      chk("t3_no_write", 32'(bus.fifo_wr_en), 32'd0);
      chk("t3_grant_id", 32'(bus.grant_id), 32'd1);
    end
    cycle(1'b0, 0, 0, 0);
    if (prev_ack[1]) p_req[1] = 1'b0;
    cycle(1'b0, 0, 0, 0);
    chk("t3_wr_en_after_full", 32'(bus.fifo_wr_en), 32'd1);
    chk("t3_data_after_full", 32'(bus.fifo_data), 32'h5A);

    // requester 0 drops after one word, requester 3 waiting
    do_reset();
    grant_log.delete();
    p_req = 4'b1001;
    p_data[0] = 8'hA0;
    p_data[3] = 8'hD3;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 0, 0, 0);
      if (prev_ack[0]) p_req[0] = 1'b0;
      if (prev_ack[3]) p_req[3] = 1'b0;
    end
    chk("t4_grant_count", 32'(grant_log.size()), 32'd2);
    chk("t4_second_grant", 32'((grant_log.size() > 1) ? grant_log[1] : -1), 32'd3);

    // reset in the middle of a burst
    do_reset();
    p_req = '1;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 0, 0, 0);
      for (int i = 0; i < NREQ; i++) if (prev_ack[i]) p_data[i] = WIDTH'($urandom);
    end
    chk("t5_midburst_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_wr_en_cleared", 32'(bus.fifo_wr_en), 32'd0);
    chk("t5_busy_cleared", 32'(bus.busy), 32'd0);
    chk("t5_ack_cleared", 32'(bus.ack), 32'd0);
    do_reset();
    grant_log.delete();
    p_req = 4'b0110;
    for (int c = 0; c < 3; c++) cycle(1'b0, 0, 0, 0);
    chk("t5_first_grant", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 32'd1);

    // every source requesting continuously: rotation order
    do_reset();
    grant_log.delete();
    for (int c = 0; c < 16; c++) cycle(1'b1, 0, 0, 100);
    chk("t2_grant_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(i % NREQ));

    // long random run, then drain every outstanding request
    do_reset();
    for (int c = 0; c < 10000; c++) cycle(1'b1, 25, 30, 40);
    for (int c = 0; c < 30; c++) cycle(1'b1, 0, 100, 0);
    @(posedge clk);
    #2;
    chk("drain_req", 32'(p_req), 32'd0);
    chk("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
